// File: rtl/cordic_polar_aligner.sv
// Pairs the independent theta and magnitude streams of a CORDIC core through two
// small FIFOs and emits one gain-compensated (theta, magnitude) pair per pop.
module cordic_polar_aligner #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4,
    parameter int K_COEF = 2487,
    parameter int K_FRAC = 12
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_theta_valid,
    input  logic signed [DATA_W-1:0] i_theta,
    input  logic                     i_mag_valid,
    input  logic signed [DATA_W-1:0] i_mag,
    input  logic                     i_out_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_theta,
    output logic signed [DATA_W-1:0] o_mag,
    output logic                     o_overflow,
    output logic [7:0]               o_pair_cnt
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PROD_W = DATA_W + K_FRAC;

    logic signed [DATA_W-1:0] r_th_mem [DEPTH];
    logic signed [DATA_W-1:0] r_mg_mem [DEPTH];
    logic [PTR_W-1:0]         r_th_wptr, r_th_rptr, r_mg_wptr, r_mg_rptr;
    logic [CNT_W-1:0]         r_th_cnt, r_mg_cnt;

    logic                     r_valid;
    logic signed [DATA_W-1:0] r_theta, r_mag;
    logic                     r_overflow;
    logic [7:0]               r_pair_cnt;

    logic                     w_th_full, w_th_empty, w_mg_full, w_mg_empty;
    logic                     w_pop, w_xfer, w_th_push, w_mg_push, w_drop;
    logic signed [DATA_W-1:0] w_th_head, w_mg_head;
    logic [DATA_W-1:0]        w_mag_raw;
    logic signed [DATA_W-1:0] w_mag_comp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign w_th_full  = (r_th_cnt == CNT_W'(DEPTH));
    assign w_mg_full  = (r_mg_cnt == CNT_W'(DEPTH));
    assign w_th_empty = (r_th_cnt == '0);
    assign w_mg_empty = (r_mg_cnt == '0);

    // Handshake: a pair moves downstream on any edge where o_valid && i_out_ready.
    // The output register refills when it is empty or being drained that same edge.
    assign w_xfer    = r_valid && i_out_ready;
    assign w_pop     = !w_th_empty && !w_mg_empty && (!r_valid || i_out_ready);
    assign w_th_push = i_theta_valid && (!w_th_full || w_pop);
    assign w_mg_push = i_mag_valid && (!w_mg_full || w_pop);
    assign w_drop    = (i_theta_valid && !w_th_push) || (i_mag_valid && !w_mg_push);

    assign w_th_head = r_th_mem[r_th_rptr];
    assign w_mg_head = r_mg_mem[r_mg_rptr];

    // Sign bit is handled separately, so only the magnitude bits feed the multiplier.
    assign w_mag_raw  = DATA_W'((PROD_W'(w_mg_head[DATA_W-2:0]) * PROD_W'(K_COEF)
                                 + (PROD_W'(1) << (K_FRAC - 1))) >> K_FRAC);
    assign w_mag_comp = w_mg_head[DATA_W-1] ? '0 : w_mag_raw;

    always_ff @(posedge clk) begin
        if (!i_rst && w_th_push) r_th_mem[r_th_wptr] <= i_theta;
        if (!i_rst && w_mg_push) r_mg_mem[r_mg_wptr] <= i_mag;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_th_wptr  <= '0;
            r_th_rptr  <= '0;
            r_th_cnt   <= '0;
            r_mg_wptr  <= '0;
            r_mg_rptr  <= '0;
            r_mg_cnt   <= '0;
            r_valid    <= 1'b0;
            r_theta    <= '0;
            r_mag      <= '0;
            r_overflow <= 1'b0;
            r_pair_cnt <= '0;
        end else begin
            if (w_th_push) r_th_wptr <= ptr_inc(r_th_wptr);
            if (w_mg_push) r_mg_wptr <= ptr_inc(r_mg_wptr);
            if (w_pop) begin
                r_th_rptr <= ptr_inc(r_th_rptr);
                r_mg_rptr <= ptr_inc(r_mg_rptr);
            end

            case ({w_th_push, w_pop})
                2'b10:   r_th_cnt <= r_th_cnt + 1'b1;
                2'b01:   r_th_cnt <= r_th_cnt - 1'b1;
                default: r_th_cnt <= r_th_cnt;
            endcase
            case ({w_mg_push, w_pop})
                2'b10:   r_mg_cnt <= r_mg_cnt + 1'b1;
                2'b01:   r_mg_cnt <= r_mg_cnt - 1'b1;
                default: r_mg_cnt <= r_mg_cnt;
            endcase

            if (w_drop) r_overflow <= 1'b1;

            if (w_pop) begin
                r_valid <= 1'b1;
                r_theta <= w_th_head;
                r_mag   <= w_mag_comp;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (w_xfer) r_pair_cnt <= r_pair_cnt + 8'd1;
        end
    end

    assign o_valid    = r_valid;
    assign o_theta    = r_theta;
    assign o_mag      = r_mag;
    assign o_overflow = r_overflow;
    assign o_pair_cnt = r_pair_cnt;

endmodule

// File: tb/tb_cordic_polar_aligner.sv
// Directed bench for cordic_polar_aligner: pairing, skew, sign clamp, overflow,
// backpressure, mid-run reset, streaming throughput and pair counter wrap.
module tb_cordic_polar_aligner;

    logic               clk;
    logic               i_rst;
    logic               i_theta_valid;
    logic signed [13:0] i_theta;
    logic               i_mag_valid;
    logic signed [13:0] i_mag;
    logic               i_out_ready;
    logic               o_valid;
    logic signed [13:0] o_theta;
    logic signed [13:0] o_mag;
    logic               o_overflow;
    logic [7:0]         o_pair_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    cordic_polar_aligner dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_theta_valid (i_theta_valid),
        .i_theta       (i_theta),
        .i_mag_valid   (i_mag_valid),
        .i_mag         (i_mag),
        .i_out_ready   (i_out_ready),
        .o_valid       (o_valid),
        .o_theta       (o_theta),
        .o_mag         (o_mag),
        .o_overflow    (o_overflow),
        .o_pair_cnt    (o_pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic tv, input int th, input logic mv, input int mg);
        i_theta_valid = tv;
        i_theta       = th[13:0];
        i_mag_valid   = mv;
        i_mag         = mg[13:0];
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input int th, input int mg);
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_theta"}, $signed(o_theta), th);
        check({tag, "_mag"}, $signed(o_mag), mg);
    endtask

    initial begin
        int stalls;
        int order_bad;

        i_rst       = 1'b1;
        i_out_ready = 1'b1;
        set_in(0, 0, 0, 0);
        tick();
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_theta", $signed(o_theta), 0);
        check("rst_mag", $signed(o_mag), 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_cnt", o_pair_cnt, 0);
        i_rst = 1'b0;

        // Basic compensation, both words on the same cycle
        set_in(1, 1234, 1, 1000);
        tick();
        set_in(0, 0, 0, 0);
        check("basic_lat", o_valid, 0);
        tick();
        check_out("basic", 1234, 607);
        check("basic_cnt_pre", o_pair_cnt, 0);
        tick();
        check("basic_drain", o_valid, 0);
        check("basic_cnt", o_pair_cnt, 1);

        // Skewed arrival: theta at cycle 0, magnitude at cycle 3
        set_in(1, -500, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        check("skew_wait1", o_valid, 0);
        tick();
        check("skew_wait2", o_valid, 0);
        set_in(0, 0, 1, 8191);
        tick();
        set_in(0, 0, 0, 0);
        check("skew_wait3", o_valid, 0);
        tick();
        check_out("skew", -500, 4973);
        tick();
        check("skew_cnt", o_pair_cnt, 2);

        // Negative magnitude clamps to zero
        set_in(1, 0, 1, -5);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        check_out("neg", 0, 0);
        tick();
        check("neg_cnt", o_pair_cnt, 3);

        // Overflow: five thetas into a four-entry FIFO, then five magnitudes
        for (int k = 1; k <= 5; k++) begin
            set_in(1, k, 0, 0);
            tick();
            if (k == 4) check("ovf_not_yet", o_overflow, 0);
        end
        check("ovf_set", o_overflow, 1);
        for (int k = 1; k <= 5; k++) begin
            set_in(0, 0, 1, 100);
            tick();
            if (k == 1) check("ovf_first_wait", o_valid, 0);
            else check_out($sformatf("ovf_pair%0d", k - 1), k - 1, 61);
        end
        set_in(0, 0, 0, 0);
        tick();
        check("ovf_drain", o_valid, 0);
        check("ovf_cnt", o_pair_cnt, 7);
        set_in(1, 77, 0, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        check_out("ovf_leftover", 77, 61);
        tick();
        check("ovf_cnt2", o_pair_cnt, 8);
        check("ovf_sticky", o_overflow, 1);

        // Backpressure: three pairs queued with ready low
        i_out_ready = 1'b0;
        set_in(1, 10, 1, 1000);
        tick();
        set_in(1, 20, 1, 2000);
        tick();
        set_in(1, 30, 1, 3000);
        tick();
        set_in(0, 0, 0, 0);
        check_out("bp_hold0", 10, 607);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check_out($sformatf("bp_hold%0d", j), 10, 607);
        end
        i_out_ready = 1'b1;
        tick();
        check_out("bp_pair2", 20, 1214);
        tick();
        check_out("bp_pair3", 30, 1822);
        tick();
        check("bp_drain", o_valid, 0);
        check("bp_cnt", o_pair_cnt, 11);

        // Mid-run reset with two pairs buffered and inputs present during reset
        i_out_ready = 1'b0;
        set_in(1, 5, 1, 200);
        tick();
        set_in(1, 6, 1, 300);
        tick();
        check("mrst_pre_valid", o_valid, 1);
        i_rst = 1'b1;
        set_in(1, 99, 1, 99);
        tick();
        i_rst       = 1'b0;
        i_out_ready = 1'b1;
        set_in(0, 0, 0, 0);
        check("mrst_valid", o_valid, 0);
        check("mrst_cnt", o_pair_cnt, 0);
        check("mrst_ovf", o_overflow, 0);
        check("mrst_theta", $signed(o_theta), 0);
        check("mrst_mag", $signed(o_mag), 0);
        tick();
        tick();
        check("mrst_no_stale", o_valid, 0);
        set_in(1, 321, 1, 4000);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        check_out("mrst_fresh", 321, 2429);
        tick();
        check("mrst_fresh_drain", o_valid, 0);
        check("mrst_fresh_cnt", o_pair_cnt, 1);

        // Continuous streaming: one pair per cycle, counter wraps 255 -> 0
        stalls    = 0;
        order_bad = 0;
        for (int i = 0; i < 255; i++) begin
            set_in(1, i, 1, i);
            tick();
            if (i >= 1) begin
                if (o_valid !== 1'b1) stalls++;
                if ($signed(o_theta) !== 14'(i - 1)) order_bad++;
            end
        end
        set_in(0, 0, 0, 0);
        check("stream_stalls", stalls, 0);
        check("stream_order", order_bad, 0);
        tick();
        check_out("stream_last", 254, 154);
        tick();
        check("stream_drain", o_valid, 0);
        check("cnt_wrap", o_pair_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_polar_aligner.md
CORDIC_POLAR_ALIGNER -- requirements
Module: cordic_polar_aligner

Interface
REQ-001 The block SHALL have parameter DATA_W, default 14, giving the width of the theta and magnitude words.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entries per input FIFO (power of 2).
REQ-003 The block SHALL have parameter K_COEF, default 2487, giving the CORDIC gain-compensation constant, unsigned, 0.60725 in Q0.K_FRAC.
REQ-004 The block SHALL have parameter K_FRAC, default 12, giving the fraction bits of K_COEF.
REQ-005 The port list SHALL be:
- clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_theta_valid  input  1  theta word valid; driven by the CORDIC ValidOut_Theda.
- i_theta  input  DATA_W  signed angle from CORDIC OutTheda.
- i_mag_valid  input  1  magnitude word valid; driven by the CORDIC ValidOut_Magnitude.
- i_mag  input  DATA_W  signed uncompensated magnitude from CORDIC Magnitude.
- i_out_ready  input  1  downstream accepts the output pair.
- o_valid  output  1  output pair valid.
- o_theta  output  DATA_W  signed angle of the pair.
- o_mag  output  DATA_W  signed gain-compensated magnitude of the pair.
- o_overflow  output  1  sticky flag: an input word was dropped.
- o_pair_cnt  output  8  count of pairs delivered.

Function
REQ-006 Theta words SHALL be pushed into a theta FIFO and magnitude words into a separate magnitude FIFO, each DEPTH entries, both first-in first-out.
REQ-007 Each FIFO SHALL push on a cycle with its valid high, provided it is not full or is popped in the same cycle.
REQ-008 The two input streams SHALL be independent; they may arrive on different cycles and with different counts.
REQ-009 A valid word arriving while its FIFO is full and not being popped SHALL be dropped, and o_overflow SHALL be set to 1.
REQ-010 o_overflow SHALL remain 1 until reset.
REQ-011 Pop condition: both FIFOs are non-empty AND (o_valid==0 OR i_out_ready==1).
REQ-012 On pop, both head entries SHALL be removed together and the output register loaded at that edge.
REQ-013 On load, o_theta SHALL equal the theta head word unchanged.
REQ-014 On load, o_mag SHALL equal floor((mag_head*K_COEF + 2^(K_FRAC-1)) / 2^K_FRAC), computed at full precision, round-half-up.
REQ-015 If mag_head < 0, o_mag SHALL be 0.
REQ-016 No saturation is needed, because K_COEF < 2^K_FRAC.
REQ-017 Latency: words present at input edge E with both FIFOs previously empty and the output free SHALL give o_valid=1 after edge E+1.
REQ-018 Throughput: with i_out_ready held at 1 and both streams continuous, the block SHALL output one pair per cycle.
REQ-019 Handshake: a pair transfers on a cycle with o_valid=1 and i_out_ready=1.
REQ-020 While o_valid=1 and i_out_ready=0, o_valid, o_theta and o_mag SHALL hold stable.
REQ-021 After a transfer with no new pop, o_valid SHALL go to 0 at the next edge.
REQ-022 o_pair_cnt SHALL increment by 1 on each transfer and wrap from 255 to 0.
REQ-023 Push and pop of the same FIFO in one cycle SHALL leave its occupancy unchanged, including when the FIFO is full.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH.
REQ-025 Full and empty SHALL be distinguished by an occupancy count 0..DEPTH.

Reset
REQ-026 While i_rst=1 at a clock edge, the block SHALL clear both FIFOs (occupancy 0, pointers 0) and set o_valid=0, o_theta=0, o_mag=0, o_overflow=0, o_pair_cnt=0.
REQ-027 Reset SHALL take priority over all pushes and pops on the same edge.
REQ-028 Inputs presented during reset SHALL be discarded.
REQ-029 Reset asserted mid-operation SHALL discard all buffered and pending pairs with no partial output.

Verification
REQ-030 Basic compensation: theta=1234 and mag=1000 with both valids in the same cycle, ready=1 -> o_valid one cycle later, o_theta=1234, o_mag=607, o_pair_cnt=1.
REQ-031 Skew: theta=-500 valid at cycle 0, mag=8191 valid at cycle 3 -> o_valid only after the cycle-3 edge +1, o_theta=-500, o_mag=4973.
REQ-032 Negative magnitude: mag=-5 with theta=0 -> o_mag=0, o_theta=0.
REQ-033 Overflow: 5 consecutive theta words 1..5 with no mag, then 5 mags of 100 -> o_overflow=1; exactly 4 pairs out with theta 1..4 and o_mag=61 each; 1 mag remains buffered.
REQ-034 Backpressure: 3 pairs queued, ready low for 3 cycles -> first pair held stable; on ready high, pairs stream on consecutive cycles in order; o_pair_cnt=3.
REQ-035 Mid-run reset: i_rst=1 for one cycle with 2 pairs buffered -> next cycle o_valid=0, o_pair_cnt=0, o_overflow=0; subsequent fresh inputs pair correctly with none of the old data.
